// File: rtl/dsp_post_adder.sv
// Post-adder/subtracter and output register stage of the DSP48A1 slice.
// Operand to P is 1 cycle and CIN to P is 2 cycles when all registers are on; with PREG/CARRYINREG/CARRYOUTREG=0 those paths are combinational.
// There is no flow control; CEP/CECARRYIN stall the registers, which hold their value while the enable is low.
// Optional macro DSP_POSTADD_OVF_EN adds the OVF port with a signed-overflow detector that is registered alongside P.
module dsp_post_adder #(
    parameter int CARRYINREG  = 1,
    parameter int CARRYOUTREG = 1,
    parameter int PREG        = 1
) (
    input  logic        CLK,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        opmode7,
    input  logic [47:0] X,
    input  logic [47:0] Z,
    input  logic        CIN,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
`ifdef DSP_POSTADD_OVF_EN
    output logic        CARRYOUTF,
    output logic        OVF
`else
    output logic        CARRYOUTF
`endif
);

    logic        cin_q;
    logic        cin_d;
    logic        cin_i;
    logic [48:0] sum;
    logic [47:0] result;
    logic        cy;
    logic [47:0] p_q;
    logic [47:0] p_d;
    logic        cy_q;
    logic        cy_d;

    // Carry-in register: load CIN when enabled, otherwise hold
    always_comb begin
        cin_d = cin_q;
        if (CECARRYIN) begin
            cin_d = CIN;
        end
    end

    // Carry-in flop with synchronous reset taking priority over the enable
    always_ff @(posedge CLK) begin
        if (RSTCARRYIN) begin
            cin_q <= 1'b0;
        end else begin
            cin_q <= cin_d;
        end
    end

    assign cin_i = (CARRYINREG != 0) ? cin_q : CIN;

    // 49-bit add/subtract on zero-extended operands; bit 48 is carry (add) or borrow (subtract)
    always_comb begin
        sum = 49'd0;
        if (opmode7) begin
            sum = {1'b0, Z} - ({1'b0, X} + {48'd0, cin_i});
        end else begin
            sum = {1'b0, Z} + {1'b0, X} + {48'd0, cin_i};
        end
    end

    assign result = sum[47:0];
    assign cy     = sum[48];

    // P register next state: load the result when enabled, otherwise hold
    always_comb begin
        p_d = p_q;
        if (CEP) begin
            p_d = result;
        end
    end

    // P flop with synchronous reset taking priority over the enable
    always_ff @(posedge CLK) begin
        if (RSTP) begin
            p_q <= 48'd0;
        end else begin
            p_q <= p_d;
        end
    end

    // Carry-out register next state: shares the carry-in enable
    always_comb begin
        cy_d = cy_q;
        if (CECARRYIN) begin
            cy_d = cy;
        end
    end

    // Carry-out flop, cleared by the carry reset, not by RSTP
    always_ff @(posedge CLK) begin
        if (RSTCARRYIN) begin
            cy_q <= 1'b0;
        end else begin
            cy_q <= cy_d;
        end
    end

    assign P         = (PREG != 0) ? p_q : result;
    assign PCOUT     = P;
    assign CARRYOUT  = (CARRYOUTREG != 0) ? cy_q : cy;
    assign CARRYOUTF = CARRYOUT;

`ifdef DSP_POSTADD_OVF_EN
    logic ovf_c;
    logic ovf_q;
    logic ovf_d;

    // Two's-complement overflow: operands effectively of like sign while the result sign flips
    always_comb begin
        ovf_c = 1'b0;
        if (opmode7) begin
            ovf_c = (X[47] != Z[47]) && (result[47] != Z[47]);
        end else begin
            ovf_c = (X[47] == Z[47]) && (result[47] != Z[47]);
        end
    end

    // OVF next state follows the P enable so it stays aligned with P
    always_comb begin
        ovf_d = ovf_q;
        if (CEP) begin
            ovf_d = ovf_c;
        end
    end

    // OVF flop shares the P reset
    always_ff @(posedge CLK) begin
        if (RSTP) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = (PREG != 0) ? ovf_q : ovf_c;
`endif

endmodule

// File: doc/dsp_post_adder.md
Name: dsp_post_adder

Overview:
- Post-adder/subtracter and output register stage of the DSP48A1 slice.
- Sits directly downstream of the X/Z/carry-select multiplexer stage.
- Consumes the X operand, Z operand and selected carry-in, then produces P, PCOUT, CARRYOUT and CARRYOUTF.
- Its registered P output is the feedback source the multiplexer stage selects for accumulation.

Parameters:
- CARRYINREG, 1, 1 = carry-in passes through a register; 0 = carry-in is combinational.
- CARRYOUTREG, 1, 1 = carry-out is registered; 0 = carry-out is combinational.
- PREG, 1, 1 = P is registered; 0 = P is combinational.

Ports:
- CLK  input  1  Single clock; all registers update on the rising edge.
- RSTP  input  1  Synchronous active-high reset for the P register.
- RSTCARRYIN  input  1  Synchronous active-high reset for the carry-in and carry-out registers.
- CEP  input  1  Clock enable for the P register.
- CECARRYIN  input  1  Clock enable for the carry-in and carry-out registers.
- opmode7  input  1  Post-adder mode: 0 = add, 1 = subtract.
- X  input  48  X operand from the multiplexer stage.
- Z  input  48  Z operand from the multiplexer stage.
- CIN  input  1  Selected carry-in from the multiplexer stage.
- P  output  48  Post-adder result.
- PCOUT  output  48  P cascade output; always equal to P.
- CARRYOUT  output  1  Carry/borrow out of the post-adder.
- CARRYOUTF  output  1  Fabric copy of CARRYOUT; always equal to CARRYOUT.

Behaviour:
- Reset is synchronous and active-high; the design has one clock, CLK.
- Register priority: reset first, then clock enable, then hold.
- Carry-in register (CARRYINREG=1):
  - RSTCARRYIN=1 clears it to 0.
  - Otherwise, when CECARRYIN=1, it loads CIN.
  - CARRYINREG=0: the internal carry is CIN directly.
- Arithmetic is 49-bit unsigned on zero-extended operands; cin_i is the internal carry.
  - opmode7=0: sum = {1'b0,Z} + {1'b0,X} + cin_i.
  - opmode7=1: sum = {1'b0,Z} - ({1'b0,X} + cin_i).
  - Result = sum[47:0] and cy = sum[48], so bit 48 is the borrow when subtracting.
  - Wrap-around is modulo 2^48; there is no saturation.
- P register (PREG=1):
  - RSTP=1 gives P = 48'h0.
  - Otherwise, when CEP=1, it loads the result.
  - PREG=0: P is combinational.
- Carry-out register (CARRYOUTREG=1):
  - RSTCARRYIN=1 clears it to 0.
  - Otherwise, when CECARRYIN=1, it loads cy.
  - CARRYOUTREG=0: CARRYOUT is combinational.
- Reset values of all registered outputs: P=0, PCOUT=0, CARRYOUT=0, CARRYOUTF=0.
- Latency with all registers enabled:
  - Operand to P: 1 cycle.
  - CIN to P: 2 cycles, because the carry-in register and the P register are in series.
- Accumulation: when the upstream Z or X mux selects P, each CEP cycle produces P(n+1) = P(n) ± X/Z.
  - This loop is legal only with PREG=1.
  - PREG=0 together with P feedback is a forbidden configuration and is not verified.
- Reset arriving mid-accumulation clears P on the next edge. Accumulation then restarts from 0 on the following enabled edge.
- RSTP and RSTCARRYIN are independent:
  - Asserting only RSTP leaves the carry registers intact.
  - Asserting only RSTCARRYIN leaves P intact.
- With CE low and no reset, every register holds its value regardless of input changes.

Optional Feature:
- Macro: DSP_POSTADD_OVF_EN.
- Defined:
  - Adds output port OVF (1 bit) and a two's-complement signed overflow detector on the 48-bit result.
  - Add mode: OVF = (X[47]==Z[47]) && (result[47]!=Z[47]).
  - Subtract mode: OVF = (X[47]!=Z[47]) && (result[47]!=Z[47]).
  - OVF is registered alongside P: same CEP/RSTP behaviour, same latency, reset value 0. It follows PREG.
- Not defined: no OVF port and no detector logic.

Test Plan:
- Reset: drive RSTP=1 and RSTCARRYIN=1 for 1 cycle with nonzero inputs -> P=0, PCOUT=0, CARRYOUT=0, CARRYOUTF=0 after the edge.
- Add with carry: X=48'h1, Z=48'hFFFF_FFFF_FFFF, CIN=1, opmode7=0, all CE=1 -> CIN is captured on edge 1. With X and Z held, P=48'h1 and CARRYOUT=1 after edge 2.
- Subtract/borrow: X=5, Z=3, CIN=0, opmode7=1 -> P=48'hFFFF_FFFF_FFFE, CARRYOUT=1. With X=3, Z=5 -> P=2, CARRYOUT=0.
- Accumulate: P fed back as Z, X=10, opmode7=0, CEP=1 for 4 cycles from reset -> P = 10, 20, 30, 40. Pulse RSTP at cycle 3 -> P=0 on that edge, then 10 on the next edge.
- Clock-enable hold: after P=40, set CEP=0 and CECARRYIN=0, change X and CIN randomly for 5 cycles -> P stays 40 and CARRYOUT is unchanged.
- DSP_POSTADD_OVF_EN (when defined): X=48'h7FFF_FFFF_FFFF, Z=1, opmode7=0 -> P=48'h8000_0000_0000, OVF=1. Then X=1, Z=1 -> OVF=0.
